// File: rtl/bpu_pkg.sv
// Shared types and helpers for the branch prediction unit: 2-bit counter
// encoding, BTB entry layout and the branch-opcode decode.
package bpu_pkg;

    typedef enum logic [1:0] {
        SNT = 2'b00,
        WNT = 2'b01,
        WT  = 2'b10,
        ST  = 2'b11
    } cnt2_e;

    localparam logic [2:0] BRANCH_OP_HI = 3'b110;

    // Tag field sized for the smallest legal table; unused upper bits stay zero.
    localparam int unsigned TAG_MAX_W = 30;

    typedef struct packed {
        logic                 valid;
        logic [TAG_MAX_W-1:0] tag;
        logic [31:0]          target;
    } btb_entry_t;

    function automatic logic is_branch(input logic [2:0] op_hi);
        return (op_hi == BRANCH_OP_HI);
    endfunction

    function automatic logic [31:0] sat_inc32(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : (v + 32'd1);
    endfunction

endpackage

// File: rtl/sat_cnt2.sv
// Next-state function of a 2-bit saturating branch counter.
module sat_cnt2
    import bpu_pkg::*;
(
    input  cnt2_e cnt_in,
    input  logic  taken,
    output cnt2_e cnt_out
);

    // Step towards the resolved direction, holding at either end.
    always_comb begin
        cnt_out = cnt_in;
        case (cnt_in)
            SNT:     cnt_out = taken ? WNT : SNT;
            WNT:     cnt_out = taken ? WT  : SNT;
            WT:      cnt_out = taken ? ST  : WNT;
            ST:      cnt_out = taken ? ST  : WT;
            default: cnt_out = WNT;
        endcase
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor: BHT of 2-bit counters plus a direct-mapped BTB, with
// EX-stage resolution. Define BPU_GSHARE_EN to XOR a global history into the BHT index.
module branch_pred_ctrl
    import bpu_pkg::*;
#(
    parameter int BHT_ENTRIES = 64,
    parameter int IDX_W       = $clog2(BHT_ENTRIES)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pc_IF,
    output logic        pred_taken_IF,
    output logic [31:0] pred_target_IF,
    input  logic [6:0]  op_ex,
    input  logic [31:0] pc_EX,
    input  logic        PCSel_EX,
    input  logic [31:0] alu,
    input  logic        pred_taken_EX,
    input  logic [31:0] pred_target_EX,
    output logic [31:0] PC_jump_EX,
    output logic        mispredict,
    output logic        flush_IF_ID,
    output logic        flush_ID_EX,
    output logic [31:0] br_cnt,
    output logic [31:0] miss_cnt
);

    cnt2_e      bht_r [BHT_ENTRIES];
    btb_entry_t btb_r [BHT_ENTRIES];
    logic [31:0] br_cnt_r;
    logic [31:0] miss_cnt_r;

    logic [IDX_W-1:0]     btb_idx_if_s, bht_idx_if_s, btb_idx_ex_s, bht_idx_ex_s;
    logic [TAG_MAX_W-1:0] tag_if_s, tag_ex_s;
    btb_entry_t           btb_rd_s;
    cnt2_e                bht_rd_s, bht_nxt_s;
    logic                 btb_hit_s, pred_taken_s, res_s, mispredict_s;
    logic [31:0]          actual_next_s, pred_next_s;
    logic                 unused_op_s;

    assign unused_op_s  = ^op_ex[3:0];
    assign btb_idx_if_s = pc_IF[IDX_W+1:2];
    assign btb_idx_ex_s = pc_EX[IDX_W+1:2];
    assign tag_if_s     = TAG_MAX_W'(pc_IF[31:IDX_W+2]);
    assign tag_ex_s     = TAG_MAX_W'(pc_EX[31:IDX_W+2]);

`ifdef BPU_GSHARE_EN
    logic [IDX_W-1:0] ghr_r;
    assign bht_idx_if_s = btb_idx_if_s ^ ghr_r;
    assign bht_idx_ex_s = btb_idx_ex_s ^ ghr_r;

    // Global history: newest resolved outcome enters at the LSB.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ghr_r <= '0;
        end else if (res_s) begin
            ghr_r <= {ghr_r[IDX_W-2:0], PCSel_EX};
        end
    end
`else
    assign bht_idx_if_s = btb_idx_if_s;
    assign bht_idx_ex_s = btb_idx_ex_s;
`endif

    // Fetch-side lookup; reads the stored state without bypassing this cycle's update.
    always_comb begin
        btb_rd_s  = btb_r[btb_idx_if_s];
        bht_rd_s  = bht_r[bht_idx_if_s];
        btb_hit_s = btb_rd_s.valid && (btb_rd_s.tag == tag_if_s);
        if (rst) begin
            pred_taken_s = 1'b0;
        end else begin
            pred_taken_s = btb_hit_s && bht_rd_s[1];
        end
    end

    assign pred_taken_IF  = pred_taken_s;
    assign pred_target_IF = pred_taken_s ? btb_rd_s.target : (pc_IF + 32'd4);

    // Resolution compares full next-PC values, so a wrong target also redirects.
    always_comb begin
        res_s         = is_branch(op_ex[6:4]);
        actual_next_s = PCSel_EX ? alu : (pc_EX + 32'd4);
        pred_next_s   = pred_taken_EX ? pred_target_EX : (pc_EX + 32'd4);
        mispredict_s  = res_s && (actual_next_s != pred_next_s);
    end

    assign PC_jump_EX  = actual_next_s;
    assign mispredict  = mispredict_s;
    assign flush_IF_ID = mispredict_s;
    assign flush_ID_EX = mispredict_s;

    sat_cnt2 u_sat_cnt2 (
        .cnt_in  (bht_r[bht_idx_ex_s]),
        .taken   (PCSel_EX),
        .cnt_out (bht_nxt_s)
    );

    // Table and statistics update on each resolved branch; reset wins over any pending write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < BHT_ENTRIES; i++) begin
                bht_r[i] <= WNT;
                btb_r[i] <= '0;
            end
            br_cnt_r   <= 32'd0;
            miss_cnt_r <= 32'd0;
        end else if (res_s) begin
            bht_r[bht_idx_ex_s] <= bht_nxt_s;
            if (PCSel_EX) begin
                btb_r[btb_idx_ex_s] <= '{valid: 1'b1, tag: tag_ex_s, target: alu};
            end
            br_cnt_r <= sat_inc32(br_cnt_r);
            if (mispredict_s) begin
                miss_cnt_r <= sat_inc32(miss_cnt_r);
            end
        end
    end

    assign br_cnt   = br_cnt_r;
    assign miss_cnt = miss_cnt_r;

endmodule

// File: tb/tb_branch_pred_ctrl.sv
// Self-checking bench for branch_pred_ctrl: directed scenarios then random
// branch traffic against a table-level reference model.
module tb_branch_pred_ctrl;

    localparam int BHT   = 64;
    localparam int IDX_W = $clog2(BHT);

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_IF;
    logic        pred_taken_IF;
    logic [31:0] pred_target_IF;
    logic [6:0]  op_ex;
    logic [31:0] pc_EX;
    logic        PCSel_EX;
    logic [31:0] alu;
    logic        pred_taken_EX;
    logic [31:0] pred_target_EX;
    logic [31:0] PC_jump_EX;
    logic        mispredict;
    logic        flush_IF_ID;
    logic        flush_ID_EX;
    logic [31:0] br_cnt;
    logic [31:0] miss_cnt;

    branch_pred_ctrl #(.BHT_ENTRIES(BHT)) dut (
        .clk(clk), .rst(rst), .pc_IF(pc_IF), .pred_taken_IF(pred_taken_IF),
        .pred_target_IF(pred_target_IF), .op_ex(op_ex), .pc_EX(pc_EX),
        .PCSel_EX(PCSel_EX), .alu(alu), .pred_taken_EX(pred_taken_EX),
        .pred_target_EX(pred_target_EX), .PC_jump_EX(PC_jump_EX),
        .mispredict(mispredict), .flush_IF_ID(flush_IF_ID), .flush_ID_EX(flush_ID_EX),
        .br_cnt(br_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: per-entry counter value 0..3 and BTB contents.
    int          m_cnt [BHT];
    bit          m_val [BHT];
    logic [31:0] m_tag [BHT];
    logic [31:0] m_tgt [BHT];
    longint      m_br, m_miss;

    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_ALU = 7'b0110011;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % BHT);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / (4 * BHT);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int s;
        s = slot(pc);
        return m_val[s] && (m_tag[s] == tag_of(pc)) && (m_cnt[s] >= 2);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < BHT; i++) begin
            m_cnt[i] = 1;
            m_val[i] = 1'b0;
            m_tag[i] = 32'd0;
            m_tgt[i] = 32'd0;
        end
        m_br   = 0;
        m_miss = 0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag);
        bit pt;
        pt = m_pred(pc_IF);
        chk({tag, "_pred_taken"}, {31'd0, pred_taken_IF}, {31'd0, pt});
        chk({tag, "_pred_target"}, pred_target_IF, pt ? m_tgt[slot(pc_IF)] : pc_IF + 32'd4);
    endtask

    // Applies one EX/IF cycle, checks combinational outputs, clocks, updates the model.
    task automatic step(input string tag, input logic [6:0] op, input logic [31:0] pc_ex,
                        input bit taken, input logic [31:0] tgt, input bit pt,
                        input logic [31:0] ptgt, input logic [31:0] pc_if);
        bit          br, mis;
        logic [31:0] actual, predicted;
        int          s;
        op_ex = op; pc_EX = pc_ex; PCSel_EX = taken; alu = tgt;
        pred_taken_EX = pt; pred_target_EX = ptgt; pc_IF = pc_if;
        br        = (op / 16) == 6;
        actual    = taken ? tgt : pc_ex + 32'd4;
        predicted = pt ? ptgt : pc_ex + 32'd4;
        mis       = br && (actual != predicted);
        #2;
        chk({tag, "_mispredict"}, {31'd0, mispredict}, {31'd0, mis});
        chk({tag, "_pc_jump"}, PC_jump_EX, actual);
        chk({tag, "_flush_if_id"}, {31'd0, flush_IF_ID}, {31'd0, mis});
        chk({tag, "_flush_id_ex"}, {31'd0, flush_ID_EX}, {31'd0, mis});
        chk_fetch(tag);
        chk({tag, "_br_cnt"}, br_cnt, 32'(m_br));
        chk({tag, "_miss_cnt"}, miss_cnt, 32'(m_miss));
        @(posedge clk);
        if (br) begin
            s = slot(pc_ex);
            m_cnt[s] = taken ? ((m_cnt[s] < 3) ? m_cnt[s] + 1 : 3)
                             : ((m_cnt[s] > 0) ? m_cnt[s] - 1 : 0);
            if (taken) begin
                m_val[s] = 1'b1;
                m_tag[s] = tag_of(pc_ex);
                m_tgt[s] = tgt;
            end
            m_br++;
            if (mis) m_miss++;
        end
        #1;
    endtask

    logic [31:0] pcs [5];
    logic [31:0] r_pc_ex, r_pc_if, r_tgt, r_ptgt;
    logic [6:0]  r_op;
    bit          r_taken, r_pt;
    int          v;

    initial begin
        pcs = '{32'h100, 32'h104, 32'h200, 32'h1100, 32'h3F0};
        rst = 1'b1; pc_IF = 32'h100; op_ex = 7'd0; pc_EX = 32'd0; PCSel_EX = 1'b0;
        alu = 32'd0; pred_taken_EX = 1'b0; pred_target_EX = 32'd0;
        model_reset();
        #2;
        chk("reset_pred_taken", {31'd0, pred_taken_IF}, 32'd0);
        chk("reset_pred_target", pred_target_IF, 32'h104);
        chk("reset_br_cnt", br_cnt, 32'd0);
        chk("reset_miss_cnt", miss_cnt, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;

        step("idle", OP_ALU, 32'h40, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
        step("first_taken", OP_BR, 32'h100, 1'b1, 32'h80, 1'b0, 32'h0, 32'h100);
        chk("trained_pred_target", pred_target_IF, 32'h80);
        chk("trained_pred_taken", {31'd0, pred_taken_IF}, 32'd1);
        for (int i = 0; i < 3; i++)
            step("retrain_taken", OP_BR, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 32'h100);
        step("not_taken", OP_BR, 32'h100, 1'b0, 32'h80, 1'b1, 32'h80, 32'h100);
        step("after_nt", OP_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h100);
        chk("after_nt_still_taken", {31'd0, pred_taken_IF}, 32'd1);
        step("correct_pred", OP_BR, 32'h100, 1'b1, 32'h80, 1'b1, 32'h80, 32'h100);
        step("non_branch_taken", OP_ALU, 32'h200, 1'b1, 32'h300, 1'b0, 32'h0, 32'h200);
        step("non_branch_check", OP_ALU, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0, 32'h200);
        step("alias_tag", OP_BR, 32'h1100, 1'b0, 32'h0, 1'b0, 32'h0, 32'h1100);

        // Asynchronous reset pulse between edges, with a branch pending in EX.
        op_ex = OP_BR; pc_EX = 32'h100; PCSel_EX = 1'b1; alu = 32'h80;
        pc_IF = 32'h100;
        #1; rst = 1'b1; #2; rst = 1'b0;
        op_ex = OP_ALU;
        model_reset();
        #1;
        chk("pulse_pred_taken", {31'd0, pred_taken_IF}, 32'd0);
        chk("pulse_pred_target", pred_target_IF, 32'h104);
        chk("pulse_br_cnt", br_cnt, 32'd0);
        chk("pulse_miss_cnt", miss_cnt, 32'd0);
        @(posedge clk);
        #1;

        for (int i = 0; i < 400; i++) begin
            r_pc_ex = pcs[$urandom_range(0, 4)];
            r_pc_if = pcs[$urandom_range(0, 4)];
            v = $urandom_range(0, 9);
            if (v < 7) begin
                r_op = {3'b110, 4'($urandom)};
            end else begin
                v = $urandom_range(0, 6);
                r_op = {(v == 6) ? 3'b111 : 3'(v), 4'($urandom)};
            end
            r_taken = 1'($urandom);
            r_tgt   = 32'($urandom_range(0, 3)) << 4;
            if ($urandom_range(0, 1) == 0) begin
                r_pt   = m_pred(r_pc_ex);
                r_ptgt = r_pt ? m_tgt[slot(r_pc_ex)] : 32'd0;
            end else begin
                r_pt   = 1'($urandom);
                r_ptgt = 32'($urandom_range(0, 3)) << 4;
            end
            step("rand", r_op, r_pc_ex, r_taken, r_tgt, r_pt, r_ptgt, r_pc_if);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
